irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 30 +++
 rtl/irq_ctrl.sv | 114 +++++++++++
 tb/tb_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: CPU-side register bus of the interrupt controller.
// Carries the active-low strobes, the decoded register selects and the
// write/read data words. The CPU side uses the master modport, the
// controller the slave modport.
interface irq_ctrl_if;
  logic        WE_L;
  logic        AS_L;
  logic        pending_reg_select;
  logic        enable_reg_select;
  logic        vector_reg_select;
  logic        mode_reg_select;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output WE_L, AS_L,
    output pending_reg_select, enable_reg_select,
    output vector_reg_select, mode_reg_select,
    output data_in,
    input  data_out
  );

  modport slave (
    input  WE_L, AS_L,
    input  pending_reg_select, enable_reg_select,
    input  vector_reg_select, mode_reg_select,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller with NUM_SRC request lines.
// Edge-mode sources latch a pending bit on a rising edge and are cleared by
// write-1-to-clear. Level-mode sources mirror the registered request line.
// Enabled pending bits are OR-ed into a registered cpu_irq, and the vector
// register reports the lowest-index enabled pending source.
// Optional feature: define IRQ_CTRL_MODE_REG_EN to get a writable per-source
// mode register (1=level, 0=edge). Without it, every source is edge mode.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq
);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] prev_src;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] active;
  // Low until the first edge after reset, so a line that is already high when
  // reset drops is not mistaken for a fresh rising edge.
  logic               primed;
  logic               bus_wr;
  logic               wr_pending;
  logic               wr_enable;
  logic               vec_valid;
  logic [4:0]         vec_id;
  logic [31:0]        vector_word;
  // Upper data_in bits beyond NUM_SRC are intentionally not stored.
  logic               unused_data_bits;

  assign bus_wr           = !bus.AS_L && !bus.WE_L;
  assign wr_pending       = bus_wr && bus.pending_reg_select;
  assign wr_enable        = bus_wr && bus.enable_reg_select;
  assign unused_data_bits = ^bus.data_in;

  assign rise     = irq_src & ~prev_src & {NUM_SRC{primed}};
  assign w1c_mask = wr_pending ? bus.data_in[NUM_SRC-1:0] : '0;
  assign active   = pending & enable;

`ifdef IRQ_CTRL_MODE_REG_EN
  logic wr_mode;
  assign wr_mode = bus_wr && bus.mode_reg_select;

  // Mode register: per-source level (1) / edge (0) selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= '0;
    end else if (wr_mode) begin
      mode <= bus.data_in[NUM_SRC-1:0];
    end
  end
`else
  assign mode = '0;
`endif

  // Edge history, pending capture (set beats W1C) and registered cpu_irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_src <= '0;
      primed   <= 1'b0;
      pending  <= '0;
      cpu_irq  <= 1'b0;
    end else begin
      prev_src <= irq_src;
      primed   <= 1'b1;
      pending  <= (mode & irq_src) | (~mode & ((pending & ~w1c_mask) | rise));
      cpu_irq  <= |active;
    end
  end

  // Enable register: a plain load, pending keeps latching while masked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= '0;
    end else if (wr_enable) begin
      enable <= bus.data_in[NUM_SRC-1:0];
    end
  end

  // Lowest-index enabled pending source wins the vector.
  always_comb begin
    vec_valid = 1'b0;
    vec_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_valid = 1'b1;
        vec_id    = 5'(i);
      end
    end
  end

  assign vector_word = {vec_valid, 26'b0, vec_id};

  // Read mux: fixed select priority, unselected or unused bits read 0.
  always_comb begin
    bus.data_out = '0;
    if (bus.pending_reg_select) begin
      bus.data_out = 32'(pending);
    end else if (bus.enable_reg_select) begin
      bus.data_out = 32'(enable);
    end else if (bus.vector_reg_select) begin
      bus.data_out = vector_word;
    end else if (bus.mode_reg_select) begin
      bus.data_out = 32'(mode);
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table, hand-written reset/collision/mode
// sequences, and a randomized phase checked against a rule-level model.
module tb_irq_ctrl;

  localparam int N = 8;
`ifdef IRQ_CTRL_MODE_REG_EN
  localparam bit MODE_EN = 1'b1;
`else
  localparam bit MODE_EN = 1'b0;
`endif

  // select bit positions inside a 4-bit select code
  localparam logic [3:0] SP = 4'b0001;
  localparam logic [3:0] SE = 4'b0010;
  localparam logic [3:0] SV = 4'b0100;
  localparam logic [3:0] SM = 4'b1000;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         cpu_irq;

  irq_ctrl_if bus();

  irq_ctrl #(.NUM_SRC(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_src (irq_src),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [N-1:0] src;
    logic         wr;
    logic [3:0]   sel;
    logic [31:0]  din;
    logic [31:0]  dout;
    logic         cpu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [N-1:0] src, input logic wr, input logic [3:0] sel,
                     input logic [31:0] din, input logic [31:0] dout, input logic cpu);
    vec_t v;
    v.src = src; v.wr = wr; v.sel = sel; v.din = din; v.dout = dout; v.cpu = cpu;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [N-1:0] src, input logic as_n, input logic we_n,
                       input logic [3:0] sel, input logic [31:0] din);
    irq_src                = src;
    bus.AS_L               = as_n;
    bus.WE_L               = we_n;
    bus.pending_reg_select = sel[0];
    bus.enable_reg_select  = sel[1];
    bus.vector_reg_select  = sel[2];
    bus.mode_reg_select    = sel[3];
    bus.data_in            = din;
  endtask

  // advance one active edge and settle away from it
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural reference model ----------------
  bit [N-1:0] m_pend, m_en, m_mode, m_prev;
  bit         m_primed, m_cpu;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
    m_primed = 1'b0; m_cpu = 1'b0;
  endtask

  task automatic model_edge(input bit [N-1:0] src, input bit wr, input bit [3:0] sel,
                            input bit [31:0] din);
    bit [N-1:0] np;
    np = m_pend;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i])                                 np[i] = src[i];
      else if (m_primed && !m_prev[i] && src[i])     np[i] = 1'b1;
      else if (wr && sel[0] && din[i])               np[i] = 1'b0;
    end
    m_cpu = ((m_pend & m_en) != 0);
    if (wr && sel[1])            m_en   = din[N-1:0];
    if (MODE_EN && wr && sel[3]) m_mode = din[N-1:0];
    m_pend   = np;
    m_prev   = src;
    m_primed = 1'b1;
  endtask

  function automatic bit [31:0] model_read(input bit [3:0] sel);
    int ids[$];
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) ids.push_back(i);
    if (sel[0]) return 32'(m_pend);
    if (sel[1]) return 32'(m_en);
    if (sel[2]) return (ids.size() == 0) ? 32'h0 : (32'h8000_0000 | 32'(ids[0]));
    if (sel[3]) return 32'(m_mode);
    return 32'h0;
  endfunction

  // -------------------------------------------------------------
  initial begin
    // directed table: inputs held across one edge, outputs checked after it
    add(8'h00, 1, SE,      32'h01,        32'h01,        0); // enable bit 0
    add(8'h01, 0, SP,      32'h0,         32'h01,        0); // rising edge src0
    add(8'h00, 0, SV,      32'h0,         32'h8000_0000, 1); // cpu_irq one later
    add(8'h00, 1, SP,      32'h01,        32'h00,        1); // W1C
    add(8'h00, 0, SP,      32'h0,         32'h00,        0);
    add(8'h00, 1, SE,      32'hFF,        32'hFF,        0); // enable all
    add(8'h24, 0, SP,      32'h0,         32'h24,        0); // bits 5 and 2
    add(8'h00, 0, SV,      32'h0,         32'h8000_0002, 1); // lowest wins
    add(8'h00, 1, SP,      32'h04,        32'h20,        1); // W1C bit 2
    add(8'h00, 0, SV,      32'h0,         32'h8000_0005, 1);
    add(8'h00, 1, SP,      32'h20,        32'h00,        1);
    add(8'h00, 0, SV,      32'h0,         32'h00,        0);
    add(8'h08, 1, SP,      32'h08,        32'h08,        0); // set beats W1C
    add(8'h08, 0, SP,      32'h0,         32'h08,        1);
    add(8'h00, 1, SP,      32'h08,        32'h00,        1);
    add(8'h00, 0, SP,      32'h0,         32'h00,        0);
    add(8'h00, 1, SE,      32'h00,        32'h00,        0); // mask all
    add(8'h10, 0, SP,      32'h0,         32'h10,        0); // latches while masked
    add(8'h00, 0, SV,      32'h0,         32'h00,        0);
    add(8'h00, 1, SE,      32'h10,        32'h10,        0); // unmask bit 4
    add(8'h00, 0, SV,      32'h0,         32'h8000_0004, 1); // two edges after write
    add(8'h00, 0, SM,      32'h0,         32'h00,        1);
    add(8'h00, 1, SV,      32'hFFFF_FFFF, 32'h8000_0004, 1); // vector write ignored
    add(8'h00, 0, 4'b0000, 32'h0,         32'h00,        1); // nothing selected
    add(8'h00, 0, SP | SE, 32'h0,         32'h10,        1); // pending has priority
    add(8'h00, 0, SE | SV, 32'h0,         32'h10,        1); // enable over vector
    add(8'h00, 1, SP,      32'h10,        32'h00,        1);

    // reset with all sources high: outputs forced to 0 while asserted
    reset = 1'b1;
    drive(8'hFF, 1'b1, 1'b1, SP, 32'h0);
    #1;
    check("rst_cpu_irq", {31'b0, cpu_irq}, 32'h0);
    check("rst_pending", bus.data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    cycle();
    check("rel_pending_held_src", bus.data_out, 32'h0);
    check("rel_cpu_irq", {31'b0, cpu_irq}, 32'h0);

    foreach (tbl[k]) begin
      drive(tbl[k].src, 1'b0, !tbl[k].wr, tbl[k].sel, tbl[k].din);
      cycle();
      check($sformatf("vec%0d_dout", k), bus.data_out, tbl[k].dout);
      check($sformatf("vec%0d_cpu", k), {31'b0, cpu_irq}, {31'b0, tbl[k].cpu});
    end

    // mid-operation reset with irq_src=0xFF
    drive(8'h00, 1'b0, 1'b0, SE, 32'hFF);
    cycle();
    drive(8'hFF, 1'b1, 1'b1, SP, 32'h0);
    cycle();
    cycle();
    check("pre_rst_cpu_irq", {31'b0, cpu_irq}, 32'h1);
    check("pre_rst_pending", bus.data_out, 32'hFF);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_irq", {31'b0, cpu_irq}, 32'h0);
    check("mid_rst_pending", bus.data_out, 32'h0);
    bus.pending_reg_select = 1'b0;
    bus.enable_reg_select  = 1'b1;
    #1;
    check("mid_rst_enable", bus.data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.pending_reg_select = 1'b1;
    bus.enable_reg_select  = 1'b0;
    cycle();
    cycle();
    check("post_rst_pending", bus.data_out, 32'h0);
    check("post_rst_cpu_irq", {31'b0, cpu_irq}, 32'h0);

`ifdef IRQ_CTRL_MODE_REG_EN
    // level mode: W1C ignored, pending follows the line
    drive(8'h00, 1'b0, 1'b0, SM, 32'h01);
    cycle();
    check("mode_readback", bus.data_out, 32'h01);
    drive(8'h01, 1'b0, 1'b0, SE, 32'h01);
    cycle();
    drive(8'h01, 1'b0, 1'b1, SP, 32'h0);
    cycle();
    check("lvl_pending_set", bus.data_out, 32'h01);
    drive(8'h01, 1'b0, 1'b0, SP, 32'h01);
    cycle();
    check("lvl_w1c_ignored", bus.data_out, 32'h01);
    drive(8'h00, 1'b0, 1'b1, SP, 32'h0);
    cycle();
    check("lvl_pending_drop", bus.data_out, 32'h00);
`endif

    // randomized phase against the model, from a fresh reset
    reset = 1'b1;
    drive(8'h00, 1'b1, 1'b1, 4'b0000, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #3;
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] src;
      logic         as_n, we_n;
      logic [3:0]   sel;
      logic [31:0]  din;
      src  = (n % 3 == 0) ? N'($urandom) : irq_src;
      as_n = ($urandom_range(0, 3) == 0);
      we_n = $urandom_range(0, 1) == 1;
      sel  = 4'($urandom);
      din  = $urandom;
      drive(src, as_n, we_n, sel, din);
      cycle();
      model_edge(src, !as_n && !we_n, sel, din);
      check($sformatf("rnd%0d_dout", n), bus.data_out, model_read(sel));
      check($sformatf("rnd%0d_cpu", n), {31'b0, cpu_irq}, {31'b0, m_cpu});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
